// File: rtl/rom_arbiter_if.sv
// Bundle of both requester ports and the ROM-side address/data pair.
// The arbiter connects through the slave modport; the requesters and ROM model connect through master.
interface rom_arbiter_if #(
    parameter int BITS         = 16,
    parameter int ADDRESS_BITS = 8
);
    logic                    a_req;
    logic [ADDRESS_BITS-1:0] a_addr;
    logic                    a_gnt;
    logic                    a_valid;
    logic [BITS-1:0]         a_data;

    logic                    b_req;
    logic [ADDRESS_BITS-1:0] b_addr;
    logic                    b_gnt;
    logic                    b_valid;
    logic [BITS-1:0]         b_data;

    logic [ADDRESS_BITS-1:0] rom_address;
    logic [BITS-1:0]         rom_data;

    modport slave (
        input  a_req, a_addr, b_req, b_addr, rom_data,
        output a_gnt, a_valid, a_data, b_gnt, b_valid, b_data, rom_address
    );

    modport master (
        output a_req, a_addr, b_req, b_addr, rom_data,
        input  a_gnt, a_valid, a_data, b_gnt, b_valid, b_data, rom_address
    );
endinterface

// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of a single-port ROM with a 1-cycle registered read.
// Grants are combinational; the owner tag follows the read by one cycle to steer VALID.
module rom_arbiter #(
    parameter int BITS          = 16,
    parameter int ADDRESS_BITS  = 8,
    parameter int PRIORITY_MODE = 0,
    parameter int MAX_WAIT      = 4
) (
    input logic          clk_i,
    input logic          rst_ni,
    rom_arbiter_if.slave bus
);
    typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_e;
    typedef enum logic {WIN_A, WIN_B} winner_e;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    owner_e                  owner_q, owner_d;
    winner_e                 last_winner_q, last_winner_d;
    logic [7:0]              starve_q, starve_d;
    logic [ADDRESS_BITS-1:0] last_addr_q, last_addr_d;
    logic [ADDRESS_BITS-1:0] rom_addr;
    logic                    a_gnt, b_gnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q       <= OWN_NONE;
            last_winner_q <= WIN_B;
            starve_q      <= 8'd0;
            last_addr_q   <= '0;
        end else begin
            owner_q       <= owner_d;
            last_winner_q <= last_winner_d;
            starve_q      <= starve_d;
            last_addr_q   <= last_addr_d;
        end
    end

    always_comb begin
        a_gnt         = 1'b0;
        b_gnt         = 1'b0;
        rom_addr      = last_addr_q;
        owner_d       = OWN_NONE;
        last_winner_d = last_winner_q;
        starve_d      = starve_q;
        last_addr_d   = last_addr_q;

        // Gating with rst_ni keeps grants low for the whole reset window, not just after an edge.
        if (rst_ni) begin
            if (bus.a_req && bus.b_req) begin
                if (PRIORITY_MODE == 0) begin
                    if (last_winner_q == WIN_B) a_gnt = 1'b1;
                    else                        b_gnt = 1'b1;
                end else begin
                    if (starve_q == MAX_WAIT_C) b_gnt = 1'b1;
                    else                        a_gnt = 1'b1;
                end
            end else begin
                a_gnt = bus.a_req;
                b_gnt = bus.b_req;
            end
        end

        if (a_gnt) begin
            rom_addr      = bus.a_addr;
            owner_d       = OWN_A;
            last_winner_d = WIN_A;
            last_addr_d   = bus.a_addr;
        end else if (b_gnt) begin
            rom_addr      = bus.b_addr;
            owner_d       = OWN_B;
            last_winner_d = WIN_B;
            last_addr_d   = bus.b_addr;
        end

        if (!bus.b_req || b_gnt)        starve_d = 8'd0;
        else if (starve_q != MAX_WAIT_C) starve_d = starve_q + 8'd1;
    end

    assign bus.a_gnt       = a_gnt;
    assign bus.b_gnt       = b_gnt;
    assign bus.rom_address = rom_addr;
    assign bus.a_valid     = (owner_q == OWN_A);
    assign bus.b_valid     = (owner_q == OWN_B);
    assign bus.a_data      = bus.rom_data[BITS-1:0];
    assign bus.b_data      = bus.rom_data[BITS-1:0];
endmodule

// File: tb/tb_rom_arbiter.sv
// Drives identical request traffic into a round-robin and a fixed-priority arbiter,
// predicts grants from the arbitration rules and scoreboards the VALID/DATA that follow.
module tb_rom_arbiter;
    localparam int MAXW = 4;

    typedef struct {
        bit          va;
        bit          vb;
        logic [15:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    exp_t q0[$];
    exp_t q1[$];

    bit         a_won_last_m[2];
    int         b_wait_m[2];
    logic [7:0] last_addr_m[2];

    always #5 clk = ~clk;

    rom_arbiter_if #(.BITS(16), .ADDRESS_BITS(8)) if0 ();
    rom_arbiter_if #(.BITS(16), .ADDRESS_BITS(8)) if1 ();

    rom_arbiter #(.BITS(16), .ADDRESS_BITS(8), .PRIORITY_MODE(0), .MAX_WAIT(MAXW))
        dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(if0));
    rom_arbiter #(.BITS(16), .ADDRESS_BITS(8), .PRIORITY_MODE(1), .MAX_WAIT(MAXW))
        dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(if1));

    // ROM contents: mem[n] = 0x1000 + n, one-cycle registered read
    always @(posedge clk) begin
        if0.rom_data <= 16'h1000 + {8'h00, if0.rom_address};
        if1.rom_data <= 16'h1000 + {8'h00, if1.rom_address};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            a_won_last_m[k] = 1'b0;
            b_wait_m[k]     = 0;
            last_addr_m[k]  = 8'h00;
        end
    endtask

    task automatic push_exp(input int k, input exp_t e);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // One bus cycle: apply inputs after the falling edge, predict and check grants, queue the response
    task automatic step(input bit rst, input bit ar, input logic [7:0] aa,
                        input bit br, input logic [7:0] ba);
        exp_t e;
        bit ga, gb;
        logic [7:0] ra;
        logic dga, dgb;
        logic [7:0] dra;
        @(negedge clk);
        rst_n = rst;
        if0.a_req = ar; if0.a_addr = aa; if0.b_req = br; if0.b_addr = ba;
        if1.a_req = ar; if1.a_addr = aa; if1.b_req = br; if1.b_addr = ba;
        #1;
        for (int k = 0; k < 2; k++) begin
            ga = 1'b0;
            gb = 1'b0;
            if (k == 0) begin dga = if0.a_gnt; dgb = if0.b_gnt; dra = if0.rom_address; end
            else        begin dga = if1.a_gnt; dgb = if1.b_gnt; dra = if1.rom_address; end
            if (!rst) begin
                model_reset();
                e = '{va: 1'b0, vb: 1'b0, d: 16'h0};
            end else begin
                if (ar && br) begin
                    if (k == 0) begin
                        if (a_won_last_m[k]) gb = 1'b1;
                        else                 ga = 1'b1;
                    end else begin
                        if (b_wait_m[k] == MAXW) gb = 1'b1;
                        else                     ga = 1'b1;
                    end
                end else begin
                    ga = ar;
                    gb = br;
                end
                ra = ga ? aa : (gb ? ba : last_addr_m[k]);
                chk($sformatf("m%0d_rom_address", k), 32'(dra), 32'(ra));
                if (ga) a_won_last_m[k] = 1'b1;
                if (gb) a_won_last_m[k] = 1'b0;
                if (ga || gb) last_addr_m[k] = ra;
                if (br && !gb) b_wait_m[k] = (b_wait_m[k] + 1 > MAXW) ? MAXW : b_wait_m[k] + 1;
                else           b_wait_m[k] = 0;
                e = '{va: ga, vb: gb, d: 16'h1000 + {8'h00, ra}};
            end
            chk($sformatf("m%0d_a_gnt", k), 32'(dga), 32'(ga));
            chk($sformatf("m%0d_b_gnt", k), 32'(dgb), 32'(gb));
            push_exp(k, e);
        end
    endtask

    // Reset asserted late in a cycle: the read granted in that cycle must never surface
    task automatic mid_reset();
        exp_t z;
        z = '{va: 1'b0, vb: 1'b0, d: 16'h0};
        #2;
        rst_n = 1'b0;
        void'(q0.pop_back());
        void'(q1.pop_back());
        q0.push_back(z);
        q1.push_back(z);
        model_reset();
    endtask

    task automatic check_out(input int k, input exp_t e);
        logic va, vb;
        logic [15:0] ad, bd;
        if (k == 0) begin va = if0.a_valid; vb = if0.b_valid; ad = if0.a_data; bd = if0.b_data; end
        else        begin va = if1.a_valid; vb = if1.b_valid; ad = if1.a_data; bd = if1.b_data; end
        chk($sformatf("m%0d_a_valid", k), 32'(va), 32'(e.va));
        chk($sformatf("m%0d_b_valid", k), 32'(vb), 32'(e.vb));
        if (e.va) chk($sformatf("m%0d_a_data", k), 32'(ad), 32'(e.d));
        if (e.vb) chk($sformatf("m%0d_b_data", k), 32'(bd), 32'(e.d));
    endtask

    // Monitor: after every rising edge, compare outputs with what was predicted for this cycle
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q0.size() > 0) begin e = q0.pop_front(); check_out(0, e); end
            if (q1.size() > 0) begin e = q1.pop_front(); check_out(1, e); end
        end
    end

    initial begin
        if0.a_req = 1'b0; if0.a_addr = '0; if0.b_req = 1'b0; if0.b_addr = '0;
        if1.a_req = 1'b0; if1.a_addr = '0; if1.b_req = 1'b0; if1.b_addr = '0;
        model_reset();
        repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);

        // Single A read right after reset release
        step(1'b1, 1'b1, 8'h05, 1'b0, 8'h00);
        $display("tx: A single read addr=05");

        // Contention from reset state: mode 0 alternates, mode 1 favours A
        step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 8'h10, 1'b1, 8'h20);
            $display("tx: contention cycle %0d A=10 B=20", i);
        end

        // Continuous contention long enough to see two forced B grants in mode 1
        step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 8'(8'h40 + i), 1'b1, 8'(8'h80 + i));
            $display("tx: starvation cycle %0d", i);
        end

        // A streams alone
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 8'(i), 1'b0, 8'h00);
            $display("tx: A stream addr=%0d", i);
        end

        // Idle after a grant: address held, VALIDs drop
        step(1'b1, 1'b1, 8'h2A, 1'b0, 8'h00);
        $display("tx: A read addr=2A then idle");
        repeat (3) step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);

        // B granted, reset lands before the read completes
        step(1'b1, 1'b0, 8'h00, 1'b1, 8'h30);
        mid_reset();
        step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h11, 1'b1, 8'h22);
        $display("tx: B read addr=30 cut by reset, then tie");

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            bit r, ar, br;
            r  = ($urandom_range(0, 49) != 0);
            ar = 1'($urandom_range(0, 1));
            br = ($urandom_range(0, 3) != 0);
            step(r, ar, 8'($urandom), br, 8'($urandom));
            $display("tx: rand %0d rst_n=%0b a_req=%0b b_req=%0b", i, r, ar, br);
        end

        repeat (3) step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        @(posedge clk);
        #4;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
